// File: rtl/ssg_env_pkg.sv
// ssg_env_pkg: shared constants and types for the multi-channel envelope generator.
//   - register address constants (reg_addr encoding)
//   - shape bit positions inside the 4-bit shape register {CONT, ATT, ALT, HOLD}
//   - shape_t packed struct overlaying those bits
package ssg_env_pkg;

    // Register select values
    localparam logic [1:0] AddrPeriodLo = 2'd0;
    localparam logic [1:0] AddrPeriodHi = 2'd1;
    localparam logic [1:0] AddrShape    = 2'd2;
    localparam logic [1:0] AddrReserved = 2'd3;

    // Shape bit positions
    localparam int unsigned ShapeHoldBit = 0;
    localparam int unsigned ShapeAltBit  = 1;
    localparam int unsigned ShapeAttBit  = 2;
    localparam int unsigned ShapeContBit = 3;

    // Field order matches the bit positions above (MSB first)
    typedef struct packed {
        logic cont;
        logic att;
        logic alt;
        logic hold;
    } shape_t;

endpackage

// File: rtl/ssg_env_unit.sv
// ssg_env_unit: one envelope channel.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   enable_i          prescaled envelope tick strobe
//   wr_period_lo_i    write strobe for period[7:0]
//   wr_period_hi_i    write strobe for period[15:8]
//   wr_shape_i        write strobe for shape (restarts the envelope)
//   wdata_i           write data
//   period_o          current 16-bit period (readback)
//   shape_o           current 4-bit shape (readback)
//   level_o           registered envelope level
//   hold_o            1 = stopped or holding
module ssg_env_unit
    import ssg_env_pkg::*;
#(
    parameter int unsigned ENV_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_i,
    input  logic                wr_period_lo_i,
    input  logic                wr_period_hi_i,
    input  logic                wr_shape_i,
    input  logic [7:0]          wdata_i,
    output logic [15:0]         period_o,
    output logic [3:0]          shape_o,
    output logic [ENV_BITS-1:0] level_o,
    output logic                hold_o
);

    localparam logic [ENV_BITS-1:0] Max  = '1;
    localparam logic [ENV_BITS-1:0] Zero = '0;
    localparam logic [ENV_BITS-1:0] One  = 1;

    logic [15:0]         period_q, period_d;
    shape_t              shape_q, shape_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [ENV_BITS-1:0] step_q, step_d;
    logic                attack_q, attack_d;
    logic                hold_q, hold_d;
    logic [ENV_BITS-1:0] level_q, level_d;

    logic [15:0] peff;
    logic [16:0] cnt_inc;

    always_comb begin
        period_d = period_q;
        shape_d  = shape_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        attack_d = attack_q;
        hold_d   = hold_q;
        level_d  = level_q;

        peff    = (period_q == 16'd0) ? 16'd1 : period_q;
        cnt_inc = {1'b0, cnt_q} + 17'd1;

        // Period writes never restart the envelope
        if (wr_period_lo_i) begin
            period_d[7:0] = wdata_i;
        end
        if (wr_period_hi_i) begin
            period_d[15:8] = wdata_i;
        end

        // A shape write wins over a coincident tick: restart only
        if (wr_shape_i) begin
            shape_d  = shape_t'(wdata_i[3:0]);
            cnt_d    = 16'd0;
            step_d   = Zero;
            attack_d = shape_d.att;
            hold_d   = 1'b0;
            level_d  = shape_d.att ? Zero : Max;
        end else if (enable_i && !hold_q) begin
            // >= so a period shrunk below the running count steps on the next tick
            if (cnt_inc >= {1'b0, peff}) begin
                cnt_d = 16'd0;
                if (step_q == Max) begin
                    if (!shape_q.cont) begin
                        hold_d  = 1'b1;
                        level_d = Zero;
                    end else if (shape_q.hold) begin
                        hold_d  = 1'b1;
                        level_d = (shape_q.att ^ shape_q.alt) ? Max : Zero;
                    end else if (shape_q.alt) begin
                        attack_d = !attack_q;
                        step_d   = Zero;
                        level_d  = attack_d ? Zero : Max;
                    end else begin
                        step_d  = Zero;
                        level_d = attack_q ? Zero : Max;
                    end
                end else begin
                    step_d  = step_q + One;
                    level_d = attack_q ? step_d : (Max - step_d);
                end
            end else begin
                cnt_d = cnt_inc[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q <= 16'd0;
            shape_q  <= '0;
            cnt_q    <= 16'd0;
            step_q   <= Zero;
            attack_q <= 1'b0;
            hold_q   <= 1'b1;
            level_q  <= Zero;
        end else begin
            period_q <= period_d;
            shape_q  <= shape_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            attack_q <= attack_d;
            hold_q   <= hold_d;
            level_q  <= level_d;
        end
    end

    assign period_o = period_q;
    assign shape_o  = shape_q;
    assign level_o  = level_q;
    assign hold_o   = hold_q;

endmodule

// File: rtl/ssg_env_multi.sv
// ssg_env_multi: CH_NUM independent SSG-style envelope generators behind a small
// register interface.
// Optional feature macro: SSG_ENV_READBACK_EN enables register readback; without it
// rdata/rdata_en are constant 0 and reg_rd is ignored.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   enable         prescaled envelope tick strobe (one clk wide)
//   reg_wr         register write strobe
//   reg_ch         target channel (>= CH_NUM is ignored)
//   reg_addr       0 period low, 1 period high, 2 shape, 3 reserved
//   reg_wdata      write data
//   reg_rd         readback strobe
//   rdata          readback data, one clk after reg_rd
//   rdata_en       readback valid
//   env_level      per-channel level, channel n at [n*ENV_BITS +: ENV_BITS]
//   env_hold       per-channel stopped/holding flag
module ssg_env_multi
    import ssg_env_pkg::*;
#(
    parameter int unsigned CH_NUM   = 3,
    parameter int unsigned ENV_BITS = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       reg_wr,
    input  logic [2:0]                 reg_ch,
    input  logic [1:0]                 reg_addr,
    input  logic [7:0]                 reg_wdata,
    input  logic                       reg_rd,
    output logic [7:0]                 rdata,
    output logic                       rdata_en,
    output logic [CH_NUM*ENV_BITS-1:0] env_level,
    output logic [CH_NUM-1:0]          env_hold
);

    logic [CH_NUM-1:0][15:0] period_all;
    logic [CH_NUM-1:0][3:0]  shape_all;

    // Channels >= CH_NUM match no generate index, so such writes fall away
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic sel;
        assign sel = reg_wr && (reg_ch == 3'(i));

        ssg_env_unit #(
            .ENV_BITS(ENV_BITS)
        ) u_unit (
            .clk           (clk),
            .reset         (reset),
            .enable_i      (enable),
            .wr_period_lo_i(sel && (reg_addr == AddrPeriodLo)),
            .wr_period_hi_i(sel && (reg_addr == AddrPeriodHi)),
            .wr_shape_i    (sel && (reg_addr == AddrShape)),
            .wdata_i       (reg_wdata),
            .period_o      (period_all[i]),
            .shape_o       (shape_all[i]),
            .level_o       (env_level[i*ENV_BITS +: ENV_BITS]),
            .hold_o        (env_hold[i])
        );
    end

`ifdef SSG_ENV_READBACK_EN
    logic [7:0] rd_mux;
    logic [7:0] rdata_q;
    logic       rdata_en_q;

    always_comb begin
        rd_mux = 8'h00;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (reg_ch == 3'(i)) begin
                case (reg_addr)
                    AddrPeriodLo: rd_mux = period_all[i][7:0];
                    AddrPeriodHi: rd_mux = period_all[i][15:8];
                    AddrShape:    rd_mux = {4'd0, shape_all[i]};
                    default:      rd_mux = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q    <= 8'h00;
            rdata_en_q <= 1'b0;
        end else begin
            rdata_q    <= reg_rd ? rd_mux : 8'h00;
            rdata_en_q <= reg_rd;
        end
    end

    assign rdata    = rdata_q;
    assign rdata_en = rdata_en_q;
`else
    logic unused_rb;
    assign unused_rb = reg_rd ^ (^period_all) ^ (^shape_all);

    assign rdata    = 8'h00;
    assign rdata_en = 1'b0;
`endif

endmodule
